// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared 640x480 timing constants, counter type and range helper.
package vga_timing_gen_pkg;
    typedef logic [15:0] cnt_t;
    localparam cnt_t H_ACTIVE = 16'd640;
    localparam cnt_t V_ACTIVE = 16'd480;
    localparam cnt_t HS_START = 16'd656;
    localparam cnt_t HS_END   = 16'd751;
    localparam cnt_t VS_START = 16'd490;
    localparam cnt_t VS_END   = 16'd491;
    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;
    localparam int CLK_DIV_DEF = 4;
    function automatic logic in_range(cnt_t x, cnt_t lo, cnt_t hi);
        return x >= lo && x <= hi;
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position, sync and pulse outputs of the timing generator.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;
    cnt_t H_address;
    cnt_t V_address;
    logic Hsync;
    logic Vsync;
    logic ActiveRegion;
    logic frame;
    logic pix_tick;
    modport master (output H_address, V_address, Hsync, Vsync, ActiveRegion, frame, pix_tick);
    modport slave  (input  H_address, V_address, Hsync, Vsync, ActiveRegion, frame, pix_tick);
endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: 16-bit enabled counter wrapping from max back to 0.
module wrap_counter
    import vga_timing_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  cnt_t max,
    output cnt_t q,
    output logic at_max
);
    cnt_t r_q;
    assign q      = r_q;
    assign at_max = r_q == max;
    always_ff @(posedge clk) begin
        if (reset)
            r_q <= '0;
        else if (en)
            r_q <= at_max ? '0 : r_q + 16'd1;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel prescaler, H/V raster counters and registered sync/active/frame outputs.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input logic clk,
    input logic reset,
    vga_timing_gen_if.master vga
);
    localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
    localparam cnt_t H_MAX = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_MAX = cnt_t'(V_TOTAL - 1);
    logic [3:0] r_div;
    logic r_hs, r_vs, r_act, r_frame;
    logic w_pix, w_pix_nxt, w_h_max, w_v_max;
    cnt_t w_h, w_v, w_h_nxt, w_v_nxt;
    assign w_pix     = r_div == DIV_MAX;
    assign w_pix_nxt = r_div == DIV_MAX - 4'd1;
    always_ff @(posedge clk) begin
        if (reset)
            r_div <= '0;
        else
            r_div <= w_pix ? '0 : r_div + 4'd1;
    end
    wrap_counter u_h (.clk(clk), .reset(reset), .en(w_pix), .max(H_MAX), .q(w_h), .at_max(w_h_max));
    wrap_counter u_v (.clk(clk), .reset(reset), .en(w_pix & w_h_max), .max(V_MAX), .q(w_v), .at_max(w_v_max));
    // Look-ahead of the counters so the registered outputs line up with the addresses they describe.
    assign w_h_nxt = w_pix ? (w_h_max ? '0 : w_h + 16'd1) : w_h;
    assign w_v_nxt = (w_pix && w_h_max) ? (w_v_max ? '0 : w_v + 16'd1) : w_v;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_act   <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_hs    <= !in_range(w_h_nxt, HS_START, HS_END);
            r_vs    <= !in_range(w_v_nxt, VS_START, VS_END);
            r_act   <= w_h_nxt < H_ACTIVE && w_v_nxt < V_ACTIVE;
            r_frame <= w_pix_nxt && w_h_nxt == H_MAX && w_v_nxt == V_MAX;
        end
    end
    assign vga.H_address    = w_h;
    assign vga.V_address    = w_v;
    assign vga.Hsync        = r_hs;
    assign vga.Vsync        = r_vs;
    assign vga.ActiveRegion = r_act;
    assign vga.frame        = r_frame;
    assign vga.pix_tick     = w_pix;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size line timing on one instance, full frames on a short-line instance.
module tb_vga_timing_gen;
    localparam int AH = 800, AV = 525, AD = 4;
    localparam int BH = 8, BV = 525, BD = 2;
    localparam int BP = BH * BV * BD;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int n_cmp = 0, n_bad = 0;
    int t_a = 0, t_b = 0, cyc = 0, last_fr = -1, fr_cnt = 0;
    vga_timing_gen_if ia ();
    vga_timing_gen_if ib ();
    vga_timing_gen #(.H_TOTAL(AH), .V_TOTAL(AV), .CLK_DIV(AD)) dut_a (.clk(clk), .reset(rst_a), .vga(ia.master));
    vga_timing_gen #(.H_TOTAL(BH), .V_TOTAL(BV), .CLK_DIV(BD)) dut_b (.clk(clk), .reset(rst_b), .vga(ib.master));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: position derived arithmetically from clocks elapsed since reset.
    task automatic model(input string id, input int t, input int ht, input int vt, input int d,
                         input logic [31:0] h, input logic [31:0] v, input logic [31:0] hs,
                         input logic [31:0] vs, input logic [31:0] act, input logic [31:0] fr,
                         input logic [31:0] pt);
        int p, eh, ev, ept;
        p   = t / d;
        eh  = p % ht;
        ev  = (p / ht) % vt;
        ept = (t % d == d - 1) ? 1 : 0;
        chk({id, "_H"}, h, eh);
        chk({id, "_V"}, v, ev);
        chk({id, "_pix_tick"}, pt, ept);
        chk({id, "_Hsync"}, hs, (eh >= 656 && eh <= 751) ? 0 : 1);
        chk({id, "_Vsync"}, vs, (ev >= 490 && ev <= 491) ? 0 : 1);
        chk({id, "_Active"}, act, (eh <= 639 && ev <= 479) ? 1 : 0);
        chk({id, "_frame"}, fr, (ept == 1 && eh == ht - 1 && ev == vt - 1) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        t_a = rst_a ? 0 : t_a + 1;
        t_b = rst_b ? 0 : t_b + 1;
        if (rst_b) last_fr = -1;
        #1;
        model("A", t_a, AH, AV, AD, ia.H_address, ia.V_address, ia.Hsync, ia.Vsync, ia.ActiveRegion, ia.frame, ia.pix_tick);
        model("B", t_b, BH, BV, BD, ib.H_address, ib.V_address, ib.Hsync, ib.Vsync, ib.ActiveRegion, ib.frame, ib.pix_tick);
        if (ib.frame) begin
            fr_cnt++;
            if (last_fr >= 0) chk("B_frame_period", cyc - last_fr, BP);
            last_fr = cyc;
        end
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk("A_rst_Hsync", ia.Hsync, 1);
        chk("A_rst_Active", ia.ActiveRegion, 1);
        chk("A_rst_frame", ia.frame, 0);
        chk("A_rst_pix_tick", ia.pix_tick, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        while (t_a < 3) step();
        chk("A_first_pix_tick", ia.pix_tick, 1);
        step();
        chk("A_H_at_clk4", ia.H_address, 1);
        while (t_a < 8) step();
        chk("A_H_at_clk8", ia.H_address, 2);
        while (t_a < 656 * AD - 1) step();
        chk("A_H655", ia.H_address, 655);
        chk("A_Hsync_at_655", ia.Hsync, 1);
        step();
        chk("A_Hsync_at_656", ia.Hsync, 0);
        while (t_a < 752 * AD) step();
        chk("A_Hsync_at_752", ia.Hsync, 1);
        while (t_a < (10 * AH + 799) * AD + 3) step();
        chk("A_wrap_pix_tick", ia.pix_tick, 1);
        chk("A_wrap_H799", ia.H_address, 799);
        chk("A_wrap_V10", ia.V_address, 10);
        chk("A_Active_blank", ia.ActiveRegion, 0);
        step();
        chk("A_wrap_H0", ia.H_address, 0);
        chk("A_wrap_V11", ia.V_address, 11);
        chk("A_Active_again", ia.ActiveRegion, 1);
        chk("B_frame_count", fr_cnt, (t_b + 1) / BP);
        // Mid-frame reset while Vsync is asserted.
        while (t_b % BP != (491 * BH + 5) * BD) step();
        chk("B_Vsync_low", ib.Vsync, 0);
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        chk("B_rst_H", ib.H_address, 0);
        chk("B_rst_V", ib.V_address, 0);
        chk("B_rst_Hsync", ib.Hsync, 1);
        chk("B_rst_Vsync", ib.Vsync, 1);
        chk("B_rst_Active", ib.ActiveRegion, 1);
        chk("B_rst_frame", ib.frame, 0);
        // Reset sampled at the edge that would raise frame.
        fr_cnt = 0;
        while (t_b % BP != BP - 2) step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        chk("B_suppressed_frame", ib.frame, 0);
        chk("B_no_pulse", fr_cnt, 0);
        while (t_b < BP - 1) step();
        chk("B_first_frame", ib.frame, 1);
        chk("B_one_pulse", fr_cnt, 1);
        step();
        chk("B_after_frame_H", ib.H_address, 0);
        chk("B_after_frame_V", ib.V_address, 0);
        for (int k = 0; k < 14; k++) begin
            n = int'($urandom_range(1500, 50));
            repeat (n) step();
            if ($urandom_range(1, 0) == 1) rst_a = 1'b1;
            if ($urandom_range(1, 0) == 1) rst_b = 1'b1;
            n = int'($urandom_range(3, 1));
            repeat (n) step();
            rst_a = 1'b0;
            rst_b = 1'b0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL accept parameter H_TOTAL, default 800, pixels per line including blanking.
REQ-002 The block SHALL accept parameter V_TOTAL, default 525, lines per frame including blanking.
REQ-003 The block SHALL accept parameter CLK_DIV, default 4, system clocks per pixel (legal range 2..16).
REQ-004 clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 H_address  output  16  current pixel column, 0..H_TOTAL-1.
REQ-007 V_address  output  16  current line, 0..V_TOTAL-1.
REQ-008 Hsync  output  1  horizontal sync, active-low.
REQ-009 Vsync  output  1  vertical sync, active-low.
REQ-010 ActiveRegion  output  1  high when H_address<=639 and V_address<=479.
REQ-011 frame  output  1  one-clk pulse marking the last pixel of each frame.
REQ-012 pix_tick  output  1  one-clk pulse on each pixel-advance cycle.

Function
REQ-013 Prescaler: the block SHALL use a counter div that counts 0..CLK_DIV-1 and wraps to 0; pix_tick SHALL be high exactly when div==CLK_DIV-1.
REQ-014 When pix_tick is high, H_address SHALL increment at the next edge; when H_address==H_TOTAL-1, it SHALL wrap to 0 instead.
REQ-015 V_address SHALL increment only on a pix_tick cycle with H_address==H_TOTAL-1; when V_address==V_TOTAL-1 at that point, it SHALL wrap to 0.
REQ-016 H_address and V_address SHALL hold their values on all non-pix_tick cycles.
REQ-017 Hsync SHALL be 0 iff H_address is in 656..751, else 1.
REQ-018 Vsync SHALL be 0 iff V_address is in 490..491, else 1.
REQ-019 Hsync, Vsync and ActiveRegion SHALL be registered, computed from next-state counter values, so they align with the current H_address/V_address with zero skew and no combinational glitches.
REQ-020 frame SHALL be high on exactly the single clk cycle where pix_tick==1, H_address==H_TOTAL-1 and V_address==V_TOTAL-1; this gives one pulse per frame, with period H_TOTAL*V_TOTAL*CLK_DIV clks.
REQ-021 Counter arithmetic SHALL be 16-bit unsigned, with the upper bits zero-extended; counters SHALL never exceed TOTAL-1.
REQ-022 Downstream object logic samples frame to advance motion; frame SHALL never assert twice within one frame, including immediately after reset.

Reset
REQ-023 While reset is high, at each edge the block SHALL set div=0, H_address=0, V_address=0, Hsync=1, Vsync=1, ActiveRegion=1 and frame=0; pix_tick=0 follows from div=0.
REQ-024 A reset asserted mid-line or mid-frame SHALL take effect at the next edge regardless of div or the counter values; no partial increment SHALL occur.
REQ-025 After reset deasserts, the first pix_tick SHALL occur CLK_DIV clks later, and the first frame pulse SHALL occur H_TOTAL*V_TOTAL*CLK_DIV clks after deassertion.

Structure
REQ-026 The shared package SHALL hold the timing constants: H_ACTIVE=640, V_ACTIVE=480, HS_START=656, HS_END=751, VS_START=490, VS_END=491, and the H_TOTAL/V_TOTAL defaults.
REQ-027 One sub-module, wrap_counter, SHALL be used: a 16-bit counter with inputs clk, reset, en and max, and outputs q and at_max (q==max). It SHALL be instantiated twice (H and V); the V instance's en SHALL be H's at_max AND pix_tick.
REQ-028 The prescaler and the sync/active registers SHALL reside in vga_timing_gen.

Verification
REQ-029 Release reset, CLK_DIV=4 -> pix_tick first high at clk 3 (clk 0 being the first edge after deassertion), then every 4 clks; H_address becomes 1 at clk 4 and 2 at clk 8.
REQ-030 Run to H_address=655 then 656 -> Hsync goes 1->0 exactly in the same cycle that H_address becomes 656; at H_address=752, Hsync returns to 1.
REQ-031 Run to H_address=799, V_address=10, pix_tick -> next cycle shows H_address=0, V_address=11; ActiveRegion is 0 for H in 640..799 and 1 again at H=0.
REQ-032 Run one full frame -> frame pulses exactly once, width 1 clk, at H=799, V=524; both counters read 0 next; the next pulse comes 1,680,000 clks later.
REQ-033 Assert reset for 1 clk at H_address=700, V_address=491 (Hsync=0, Vsync=0) -> next cycle shows H=0, V=0, Hsync=1, Vsync=1, ActiveRegion=1, frame=0.
REQ-034 Assert reset on a cycle where frame would be high -> frame stays 0 and no pulse is emitted for that frame.
